mem_bus_ctlr: RTL and testbench

Bus-cycle controller between the v810 external bus and the memory/peripheral side: data_bus_resizer, RAM and I/O.
- Latches the address at bus-cycle start and decodes it into one of three regions.
- Drives per-region chip selects and OEn/WEn strobes.
- Inserts per-region programmable wait states, then returns READYn/SZRQn to the CPU.
- Unmapped accesses are terminated by a timeout and reported as a bus error.
- Replaces the ad-hoc combinational decode and READYn glue in the system top.

---
 rtl/mem_bus_ctlr.sv | 158 +++++++++++++++
 tb/tb_mem_bus_ctlr.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_ctlr.sv
// rtl/mem_bus_ctlr.sv - v810 bus-cycle controller: region decode, strobes, wait states, timeout
module mem_bus_ctlr #(
  parameter logic [31:0] R0_MATCH = 32'h0000_0000,
  parameter logic [31:0] R0_MASK  = 32'h8000_0000,
  parameter int          R0_WS    = 0,
  parameter bit          R0_W16   = 1'b0,
  parameter logic [31:0] R1_MATCH = 32'hFFF0_0000,
  parameter logic [31:0] R1_MASK  = 32'hFFF0_0000,
  parameter int          R1_WS    = 2,
  parameter bit          R1_W16   = 1'b1,
  parameter logic [31:0] R2_MATCH = 32'h0200_0000,
  parameter logic [31:0] R2_MASK  = 32'hFF00_0000,
  parameter int          R2_WS    = 1,
  parameter bit          R2_W16   = 1'b0,
  parameter int          TIMEOUT  = 63
) (
  input  logic        CLK,
  input  logic        RESn,
  input  logic        CE,
  input  logic [31:0] A,
  input  logic        BCYSTn,
  input  logic        MRQn,
  input  logic        DAn,
  input  logic        RW,
  input  logic [3:0]  BEn,
  output logic        READYn,
  output logic        SZRQn,
  output logic [2:0]  CSn,
  output logic        OEn,
  output logic        WEn,
  output logic        BUSERR,
  output logic [31:0] BUSERR_A
);

  localparam logic [7:0] WS0  = (R0_WS > 15) ? 8'd15 : 8'(R0_WS);
  localparam logic [7:0] WS1  = (R1_WS > 15) ? 8'd15 : 8'(R1_WS);
  localparam logic [7:0] WS2  = (R2_WS > 15) ? 8'd15 : 8'(R2_WS);
  localparam logic [7:0] TOUT_CNT = 8'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, WAIT, ACK, TOUT} state_t;

  state_t      state;
  logic [7:0]  cnt;
  logic [31:0] a_q;
  logic [3:0]  ben_q;
  logic        w16_q;

  logic        dec_mapped;
  logic        dec_w16;
  logic [7:0]  dec_ws;
  logic [2:0]  dec_csn;

  // A 16-bit port needs a second transfer only when both halfwords carry enabled bytes.
  function automatic logic spans_halves(input logic [3:0] ben);
    return (ben[1:0] != 2'b11) && (ben[3:2] != 2'b11);
  endfunction

  always_comb begin
    dec_mapped = 1'b1;
    dec_w16    = 1'b0;
    dec_ws     = TOUT_CNT;
    dec_csn    = 3'b111;
    if (!MRQn && ((A & R0_MASK) == R0_MATCH)) begin
      dec_w16 = R0_W16;
      dec_ws  = WS0;
      dec_csn = 3'b110;
    end else if (!MRQn && ((A & R1_MASK) == R1_MATCH)) begin
      dec_w16 = R1_W16;
      dec_ws  = WS1;
      dec_csn = 3'b101;
    end else if (!MRQn && ((A & R2_MASK) == R2_MATCH)) begin
      dec_w16 = R2_W16;
      dec_ws  = WS2;
      dec_csn = 3'b011;
    end else begin
      dec_mapped = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RESn) begin
    if (!RESn) begin
      state    <= IDLE;
      cnt      <= 8'd0;
      a_q      <= 32'd0;
      ben_q    <= 4'hF;
      w16_q    <= 1'b0;
      READYn   <= 1'b1;
      SZRQn    <= 1'b1;
      CSn      <= 3'b111;
      OEn      <= 1'b1;
      WEn      <= 1'b1;
      BUSERR   <= 1'b0;
      BUSERR_A <= 32'd0;
    end else if (CE) begin
      BUSERR <= 1'b0;
      // A new cycle may start from IDLE or straight out of ACK (back-to-back).
      if ((state == IDLE || state == ACK) && !BCYSTn) begin
        a_q    <= A;
        ben_q  <= BEn;
        w16_q  <= dec_w16;
        READYn <= 1'b1;
        SZRQn  <= 1'b1;
        if (dec_mapped) begin
          CSn <= dec_csn;
          OEn <= ~RW;
          WEn <= RW;
          if (dec_ws == 8'd0) begin
            state  <= ACK;
            cnt    <= 8'd0;
            READYn <= 1'b0;
            SZRQn  <= ~(dec_w16 && spans_halves(BEn));
          end else begin
            state <= WAIT;
            cnt   <= dec_ws;
          end
        end else begin
          CSn   <= 3'b111;
          OEn   <= 1'b1;
          WEn   <= 1'b1;
          cnt   <= TOUT_CNT;
          state <= TOUT;
        end
      end else begin
        case (state)
          // Leaving on count 1 makes the access latency exactly WS+1 CE cycles.
          WAIT: if (!DAn) begin
            cnt <= cnt - 8'd1;
            if (cnt == 8'd1) begin
              state  <= ACK;
              READYn <= 1'b0;
              SZRQn  <= ~(w16_q && spans_halves(ben_q));
            end
          end
          TOUT: begin
            cnt <= cnt - 8'd1;
            if (cnt == 8'd1) begin
              state    <= ACK;
              READYn   <= 1'b0;
              SZRQn    <= 1'b1;
              BUSERR   <= 1'b1;
              BUSERR_A <= a_q;
            end
          end
          ACK: begin
            state  <= IDLE;
            READYn <= 1'b1;
            SZRQn  <= 1'b1;
            CSn    <= 3'b111;
            OEn    <= 1'b1;
            WEn    <= 1'b1;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mem_bus_ctlr.sv
// tb/tb_mem_bus_ctlr.sv - self-checking bench for mem_bus_ctlr
module tb_mem_bus_ctlr;

  logic        CLK = 1'b0;
  logic        RESn, CE, BCYSTn, MRQn, DAn, RW;
  logic [31:0] A;
  logic [3:0]  BEn;
  logic        READYn, SZRQn, OEn, WEn, BUSERR;
  logic [2:0]  CSn;
  logic [31:0] BUSERR_A;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    logic [31:0] addr;
    logic        rw;
    logic [3:0]  ben;
    logic        mrqn;
    int          ws;
    logic [2:0]  csn;
    logic        oen;
    logic        wen;
    logic        szrq;
    logic        buserr;
    int          stall_kind;
    int          stall_len;
  } vec_t;

  typedef struct {
    int          cyc;
    logic        szrq;
    logic        buserr;
    logic [31:0] addr;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[10];

  // R0 narrowed to 0x00xx_xxxx so that the R2 and unmapped addresses are reachable.
  mem_bus_ctlr #(.R0_MASK(32'hFF00_0000)) dut (
    .CLK(CLK), .RESn(RESn), .CE(CE), .A(A), .BCYSTn(BCYSTn), .MRQn(MRQn),
    .DAn(DAn), .RW(RW), .BEn(BEn), .READYn(READYn), .SZRQn(SZRQn), .CSn(CSn),
    .OEn(OEn), .WEn(WEn), .BUSERR(BUSERR), .BUSERR_A(BUSERR_A)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge CLK) begin
    if (RESn === 1'b1 && READYn === 1'b0) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_ready: got READYn=0 at cycle %0d expected no transfer", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("ready_latency", cyc, e.cyc);
        check("szrq", SZRQn, e.szrq);
        check("buserr_pulse", BUSERR, e.buserr);
        if (e.buserr) check("buserr_a", BUSERR_A, e.addr);
      end
    end
  end

  task automatic push_exp(input vec_t v);
    exp_t e;
    e.cyc    = cyc + 1 + v.ws + v.stall_len;
    e.szrq   = v.szrq;
    e.buserr = v.buserr;
    e.addr   = v.addr;
    sb.push_back(e);
  endtask

  task automatic drive_start(input vec_t v);
    A = v.addr; RW = v.rw; BEn = v.ben; MRQn = v.mrqn;
    BCYSTn = 1'b0; DAn = 1'b0; CE = 1'b1;
  endtask

  task automatic wait_ready(input vec_t v);
    int j = 0;
    while (READYn !== 1'b0 && j < 300) begin
      DAn = (v.stall_kind == 1 && j < v.stall_len) ? 1'b1 : 1'b0;
      CE  = (v.stall_kind == 2 && j < v.stall_len) ? 1'b0 : 1'b1;
      @(negedge CLK);
      if (v.stall_kind != 0 && j < v.stall_len) check("stall_csn_hold", CSn, v.csn);
      j++;
    end
    check("ready_seen", READYn, 1'b0);
    check("csn_in_ack", CSn, v.csn);
    DAn = 1'b1; CE = 1'b1;
  endtask

  task automatic do_access(input vec_t v);
    drive_start(v);
    push_exp(v);
    @(negedge CLK);
    BCYSTn = 1'b1;
    check("csn_start", CSn, v.csn);
    check("oen_start", OEn, v.oen);
    check("wen_start", WEn, v.wen);
    wait_ready(v);
    @(negedge CLK);
    check("ready_deassert", READYn, 1'b1);
    check("csn_idle", CSn, 3'b111);
    check("oen_idle", OEn, 1'b1);
    check("wen_idle", WEn, 1'b1);
    check("buserr_idle", BUSERR, 1'b0);
  endtask

  initial begin
    vec_t v0, v1;
    vecs[0] = '{32'h0000_0010, 1'b1, 4'h0, 1'b0, 0,  3'b110, 1'b0, 1'b1, 1'b1, 1'b0, 0, 0};
    vecs[1] = '{32'hFFF0_0100, 1'b1, 4'h0, 1'b0, 2,  3'b101, 1'b0, 1'b1, 1'b0, 1'b0, 0, 0};
    vecs[2] = '{32'hFFF0_0100, 1'b1, 4'hC, 1'b0, 2,  3'b101, 1'b0, 1'b1, 1'b1, 1'b0, 0, 0};
    vecs[3] = '{32'h0200_0004, 1'b0, 4'h0, 1'b0, 1,  3'b011, 1'b1, 1'b0, 1'b1, 1'b0, 0, 0};
    vecs[4] = '{32'h0200_0004, 1'b0, 4'h0, 1'b0, 1,  3'b011, 1'b1, 1'b0, 1'b1, 1'b0, 1, 3};
    vecs[5] = '{32'hFFF0_0200, 1'b0, 4'h9, 1'b0, 2,  3'b101, 1'b1, 1'b0, 1'b0, 1'b0, 2, 2};
    vecs[6] = '{32'h4000_0000, 1'b1, 4'h0, 1'b0, 63, 3'b111, 1'b1, 1'b1, 1'b1, 1'b1, 0, 0};
    vecs[7] = '{32'h0000_0010, 1'b1, 4'h0, 1'b1, 63, 3'b111, 1'b1, 1'b1, 1'b1, 1'b1, 0, 0};
    vecs[8] = '{32'hFFF0_0004, 1'b1, 4'h3, 1'b0, 2,  3'b101, 1'b0, 1'b1, 1'b1, 1'b0, 0, 0};
    vecs[9] = '{32'h00FF_FFFC, 1'b0, 4'h0, 1'b0, 0,  3'b110, 1'b1, 1'b0, 1'b1, 1'b0, 0, 0};

    RESn = 1'b0; CE = 1'b1; BCYSTn = 1'b1; MRQn = 1'b0; DAn = 1'b1; RW = 1'b1;
    A = 32'd0; BEn = 4'hF;
    repeat (3) @(negedge CLK);
    check("rst_readyn", READYn, 1'b1);
    check("rst_szrqn", SZRQn, 1'b1);
    check("rst_csn", CSn, 3'b111);
    check("rst_oen", OEn, 1'b1);
    check("rst_wen", WEn, 1'b1);
    check("rst_buserr", BUSERR, 1'b0);
    check("rst_buserr_a", BUSERR_A, 32'd0);
    RESn = 1'b1;
    @(negedge CLK);

    for (int i = 0; i < 10; i++) do_access(vecs[i]);

    // Back-to-back: R1 start sampled in the R0 ACK cycle, no all-high CSn gap.
    v0 = vecs[0];
    v1 = vecs[1];
    drive_start(v0);
    push_exp(v0);
    @(negedge CLK);
    check("b2b_r0_ready", READYn, 1'b0);
    check("b2b_r0_csn", CSn, 3'b110);
    drive_start(v1);
    push_exp(v1);
    @(negedge CLK);
    BCYSTn = 1'b1;
    check("b2b_r1_csn", CSn, 3'b101);
    check("b2b_gap_ready", READYn, 1'b1);
    wait_ready(v1);
    @(negedge CLK);
    check("b2b_csn_idle", CSn, 3'b111);

    // Asynchronous reset in the middle of an R1 wait period.
    drive_start(v1);
    @(negedge CLK);
    BCYSTn = 1'b1;
    check("mid_csn", CSn, 3'b101);
    @(negedge CLK);
    #2 RESn = 1'b0;
    #1;
    check("arst_readyn", READYn, 1'b1);
    check("arst_szrqn", SZRQn, 1'b1);
    check("arst_csn", CSn, 3'b111);
    check("arst_oen", OEn, 1'b1);
    check("arst_wen", WEn, 1'b1);
    check("arst_buserr_a", BUSERR_A, 32'd0);
    @(negedge CLK);
    RESn = 1'b1;
    repeat (4) begin
      @(negedge CLK);
      check("no_ready_after_abandon", READYn, 1'b1);
    end
    do_access(vecs[0]);

    repeat (2) @(negedge CLK);
    check("sb_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish before 200000");
    $fatal(1);
  end

endmodule
